// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer and the downstream detector bench:
// FSM state encoding and default word width / idle level.
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b1;

endpackage : ser_pkg

// File: rtl/word_hold_reg.sv
// One-entry valid/data holding register used as the skid slot between the
// input handshake and the shift register.
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Clear wins over load; the parent never asks for both in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_in;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule : word_hold_reg

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and
// emits one bit per clock on x, back-to-back words with no gap cycles.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_data is sampled at that edge, and the producer keeps in_valid high with
// stable data until then. in_ready depends only on registered state.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load;
  logic             hold_clear;

  logic             active;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign active   = (state_q == S_SHIFT);
  assign last_bit = active && (bitcnt_q == LAST_CNT);
  assign accept   = in_valid && in_ready;
  // Move the next bit toward whichever end drives x.
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .data_in(in_data),
    .clear  (hold_clear),
    .valid  (hold_valid),
    .data   (hold_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d  = in_data;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          shreg_d   = shifted;
          bitcnt_d  = bitcnt_q + 1'b1;
          hold_load = accept;
        end else if (hold_valid) begin
          // Held word takes the slot right after the last bit.
          shreg_d    = hold_data;
          bitcnt_d   = '0;
          hold_clear = 1'b1;
        end else if (accept) begin
          shreg_d  = in_data;
          bitcnt_d = '0;
        end else begin
          state_d  = S_IDLE;
          bitcnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        hold_clear = 1'b1;
      end
    endcase
  end

  assign x         = active ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;
  assign x_valid   = active;
  assign word_done = last_bit;
  assign in_ready  = !hold_valid;
  assign busy      = active || hold_valid;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an expected-bit queue predicts every output each
// cycle, plus directed word sequences and an LSB-first instance.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         x;
  logic         x_valid;
  logic         word_done;
  logic         busy;

  logic [W-1:0] lsb_data;
  logic         lsb_valid;
  logic         lsb_ready;
  logic         lsb_x;
  logic         lsb_x_valid;
  logic         lsb_word_done;
  logic         lsb_busy;

  int n_checks;
  int n_pass;

  // Expected serial bits, front = bit currently on x.
  logic [0:0]  exp_q[$];
  logic [31:0] seen;
  int          seen_n;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .x_valid(x_valid), .word_done(word_done),
    .busy(busy)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(lsb_data), .in_valid(lsb_valid),
    .in_ready(lsb_ready), .x(lsb_x), .x_valid(lsb_x_valid),
    .word_done(lsb_word_done), .busy(lsb_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic bit exp_ready();
    return exp_q.size() <= W;
  endfunction

  // Scoreboard: at most two words live (shifting + held), so the number of
  // remaining bits determines every handshake/status output.
  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("x",         32'(x),         (n > 0) ? 32'(exp_q[0]) : 32'd1);
    check("x_valid",   32'(x_valid),   32'(n > 0));
    check("word_done", 32'(word_done), 32'((n > 0) && (n % W == 1)));
    check("in_ready",  32'(in_ready),  32'(n <= W));
    check("busy",      32'(busy),      32'(n > 0));
    if (x_valid) begin
      seen   = {seen[30:0], x};
      seen_n++;
    end
  endtask

  // Driver: present inputs, advance one clock, update model, check outputs.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    bit acc;
    in_valid = v;
    in_data  = d;
    acc = v && exp_ready();
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) for (int b = W - 1; b >= 0; b--) exp_q.push_back(d[b]);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    repeat (2 * W + 2) cycle(1'b0, '0);
  endtask

  initial begin
    bit           pend_v;
    logic [W-1:0] pend_d;
    bit           acc;
    logic [W-1:0] w;

    n_checks  = 0;
    n_pass    = 0;
    seen      = '0;
    seen_n    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    lsb_valid = 1'b0;
    lsb_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    cycle(1'b0, '0);

    // Single word
    seen_n = 0;
    cycle(1'b1, 8'h0A);
    drain();
    check("single_bits", seen[7:0], 32'h0A);
    check("single_cnt",  32'(seen_n), 32'd8);

    // Back-to-back with valid held high
    seen_n = 0;
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h3C);
    drain();
    check("b2b_bits", seen[15:0], 32'hA53C);
    check("b2b_cnt",  32'(seen_n), 32'd16);

    // Second word arrives exactly at the last-bit edge
    seen_n = 0;
    cycle(1'b1, 8'h0A);
    repeat (W - 1) cycle(1'b0, '0);
    cycle(1'b1, 8'hC3);
    drain();
    check("lastedge_bits", seen[15:0], 32'h0AC3);
    check("lastedge_cnt",  32'(seen_n), 32'd16);

    // Reset mid-word with a held word
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'h00);
    cycle(1'b0, '0);
    #2 rst = 1'b1;
    #1;
    check("rst_x",        32'(x),        32'd1);
    check("rst_x_valid",  32'(x_valid),  32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0);
    seen_n = 0;
    cycle(1'b1, 8'h81);
    drain();
    check("post_rst_bits", seen[7:0], 32'h81);
    check("post_rst_cnt",  32'(seen_n), 32'd8);

    // LSB-first instance
    lsb_valid = 1'b1;
    lsb_data  = 8'h0A;
    cycle(1'b0, '0);
    lsb_valid = 1'b0;
    w = 8'h0A;
    for (int k = 0; k < W; k++) begin
      check("lsb_x",         32'(lsb_x),         32'(w[k]));
      check("lsb_x_valid",   32'(lsb_x_valid),   32'd1);
      check("lsb_word_done", 32'(lsb_word_done), 32'(k == W - 1));
      cycle(1'b0, '0);
    end
    check("lsb_idle_x",     32'(lsb_x),       32'd1);
    check("lsb_idle_valid", 32'(lsb_x_valid), 32'd0);

    // Random traffic against the model
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        pend_v = 1'b1;
        pend_d = W'($urandom);
      end
      acc = pend_v && exp_ready();
      cycle(pend_v, pend_d);
      if (acc) pend_v = 1'b0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bit_serializer
